switch_arbiter_rr: RTL and testbench

- Parametrised successor of the 4-port switch arbiter: N inputs, N outputs, one independent round-robin arbiter per output.
- Each grant is locked for a whole packet and held until the owning input completes its end-of-packet handshake.
- An optional lock timeout forcibly releases stuck packets.
- Sits between the input port queues and the output crossbar muxes; drives the crossbar mux selects and the per-input ready/grant signals.

---
 rtl/switch_arbiter_rr_pkg.sv | 48 ++++
 rtl/switch_arbiter_rr_out_arbiter.sv | 98 +++++++++
 rtl/switch_arbiter_rr.sv | 79 +++++++
 tb/tb_switch_arbiter_rr.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin switch arbiter: state encoding,
// destination decode and the rotating-priority pick.
package switch_arb_pkg;

    localparam int MAX_PORTS = 16;
    localparam int MAX_SEL_W = 4;
    localparam int DEF_PORTS = 4;
    localparam int DEF_SEL_W = $clog2(DEF_PORTS);

    typedef logic [DEF_SEL_W-1:0] port_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
    } rr_pick_t;

    // Keeps only the lowest set bit; a zero mask stays zero.
    function automatic logic [MAX_PORTS-1:0] onehot_lowest(input logic [MAX_PORTS-1:0] v);
        return v & (~v + MAX_PORTS'(1));
    endfunction

    // First requester at or after ptr, wrapping modulo n. Scanning from the
    // far end lets the nearest requester overwrite the result last.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [MAX_SEL_W-1:0] ptr,
                                         input int n);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = MAX_PORTS - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_SEL_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = idx[MAX_SEL_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/switch_arbiter_rr_out_arbiter.sv
// Per-output packet-locking round-robin arbiter: owner register, rotating
// pointer and optional stuck-lock timeout.
module rr_out_arbiter
    import switch_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int SEL_W        = $clog2(NUM_PORTS),
    parameter int LOCK_TIMEOUT = 0,
    parameter int TO_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] in_valid,
    input  logic [NUM_PORTS-1:0] in_last,
    input  logic                 out_ready,
    output logic                 locked,
    output logic [SEL_W-1:0]     owner,
    output logic                 timeout_pulse
);

    localparam bit                  TO_EN   = (LOCK_TIMEOUT > 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_EN ? TO_CNT_W'(LOCK_TIMEOUT - 1) : '0;

    arb_state_e           state_q, state_d;
    logic [SEL_W-1:0]     owner_q, owner_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d, ptr_adv;
    logic [TO_CNT_W-1:0]  cnt_q, cnt_d;
    logic                 accept, eop, to_hit;
    logic [NUM_PORTS-1:0] req_rel;
    rr_pick_t             pick_idle, pick_rel;
    logic                 unused_pick_bits;

    // Upper index bits are always zero when NUM_PORTS < 16.
    assign unused_pick_bits = ^{pick_idle.idx, pick_rel.idx};

    always_comb begin
        accept  = (state_q == LOCKED) && in_valid[owner_q] && out_ready;
        eop     = accept && in_last[owner_q];
        to_hit  = TO_EN && (state_q == LOCKED) && !accept && (cnt_q == TO_LAST);
        ptr_adv = (int'(owner_q) == NUM_PORTS - 1) ? '0 : owner_q + 1'b1;

        // The owner's last flit is consumed this cycle, so it is not a pending request.
        req_rel = req;
        if (eop) req_rel[owner_q] = 1'b0;

        pick_idle = rr_pick(MAX_PORTS'(req), MAX_SEL_W'(ptr_q), NUM_PORTS);
        pick_rel  = rr_pick(MAX_PORTS'(req_rel), MAX_SEL_W'(ptr_adv), NUM_PORTS);

        state_d       = state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        timeout_pulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    state_d = LOCKED;
                    owner_d = SEL_W'(pick_idle.idx);
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (accept) cnt_d = '0;
                else if (TO_EN) cnt_d = cnt_q + 1'b1;

                // Release and rearbitrate in the same cycle so back-to-back packets see no bubble.
                if (eop || to_hit) begin
                    ptr_d         = ptr_adv;
                    cnt_d         = '0;
                    timeout_pulse = to_hit;
                    if (pick_rel.found) owner_d = SEL_W'(pick_rel.idx);
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked = (state_q == LOCKED);
    assign owner  = owner_q;

endmodule

// File: rtl/switch_arbiter_rr.sv
// N x N switch arbiter: decodes one-hot destinations into per-output requests,
// runs one locking round-robin arbiter per output and folds grants back to inputs.
module switch_arbiter_rr
    import switch_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int SEL_W        = $clog2(NUM_PORTS),
    parameter int LOCK_TIMEOUT = 0,
    parameter int TO_CNT_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 in_valid,
    input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  in_dst,
    input  logic [NUM_PORTS-1:0]                 in_last,
    input  logic [NUM_PORTS-1:0]                 out_ready,
    output logic [NUM_PORTS-1:0]                 in_ready,
    output logic [NUM_PORTS-1:0]                 grant_bus,
    output logic [NUM_PORTS-1:0][SEL_W-1:0]      mux_select,
    output logic [NUM_PORTS-1:0]                 out_active,
    output logic                                 dst_err,
    output logic [NUM_PORTS-1:0]                 timeout_pulse
);

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] dst_sel;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0]                dst_multi;

    // req[j][i]: input i wants output j; only the lowest destination bit counts.
    always_comb begin
        dst_sel   = '0;
        req       = '0;
        dst_multi = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dst_sel[i]   = NUM_PORTS'(onehot_lowest(MAX_PORTS'(in_dst[i])));
            dst_multi[i] = in_valid[i] && (in_dst[i] != dst_sel[i]);
            for (int j = 0; j < NUM_PORTS; j++) begin
                req[j][i] = in_valid[i] & dst_sel[i][j];
            end
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
        rr_out_arbiter #(
            .NUM_PORTS   (NUM_PORTS),
            .SEL_W       (SEL_W),
            .LOCK_TIMEOUT(LOCK_TIMEOUT),
            .TO_CNT_W    (TO_CNT_W)
        ) u_arb (
            .clk          (clk),
            .rst_n        (rst_n),
            .req          (req[j]),
            .in_valid     (in_valid),
            .in_last      (in_last),
            .out_ready    (out_ready[j]),
            .locked       (out_active[j]),
            .owner        (mux_select[j]),
            .timeout_pulse(timeout_pulse[j])
        );
    end

    // An input owns at most one output, so OR-folding yields that output's ready.
    always_comb begin
        grant_bus = '0;
        in_ready  = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (out_active[j]) begin
                grant_bus[mux_select[j]] = 1'b1;
                in_ready[mux_select[j]]  = in_ready[mux_select[j]] | out_ready[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dst_err <= 1'b0;
        else if (|dst_multi) dst_err <= 1'b1;
    end

endmodule

// File: tb/tb_switch_arbiter_rr.sv
// Directed bench for switch_arbiter_rr (4 ports, lock timeout of 8 cycles).
module tb_switch_arbiter_rr;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      in_valid, in_last, out_ready;
    logic [3:0][3:0] in_dst;
    logic [3:0]      in_ready, grant_bus, out_active, timeout_pulse;
    logic [3:0][1:0] mux_select;
    logic            dst_err;
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    switch_arbiter_rr #(
        .NUM_PORTS(4), .LOCK_TIMEOUT(8), .TO_CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dst(in_dst),
        .in_last(in_last), .out_ready(out_ready), .in_ready(in_ready),
        .grant_bus(grant_bus), .mux_select(mux_select), .out_active(out_active),
        .dst_err(dst_err), .timeout_pulse(timeout_pulse)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_last  = '0;
        in_dst   = '0;
        out_ready = 4'hF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL rst_active got=%b want=0000", out_active); end
        n_chk++; if (grant_bus !== 4'b0000) begin n_fail++; $display("FAIL rst_grant got=%b want=0000", grant_bus); end
        n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b want=0000", in_ready); end
        n_chk++; if (mux_select !== 8'h00) begin n_fail++; $display("FAIL rst_mux got=%h want=00", mux_select); end
        n_chk++; if (dst_err !== 1'b0) begin n_fail++; $display("FAIL rst_dst_err got=%b want=0", dst_err); end
        n_chk++; if (timeout_pulse !== 4'b0000) begin n_fail++; $display("FAIL rst_pulse got=%b want=0000", timeout_pulse); end
        rst_n = 1'b1;
        // valid with an empty destination: no request, no error
        in_valid = 4'b0001;
        next_cycle();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL zero_dst_active got=%b want=0000", out_active); end
        n_chk++; if (dst_err !== 1'b0) begin n_fail++; $display("FAIL zero_dst_err got=%b want=0", dst_err); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_packet_lock();
        clear_inputs();
        in_valid  = 4'b0101;
        in_dst[0] = 4'b0010;
        in_dst[2] = 4'b0010;
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t1_latency got=%b want=0000", out_active); end
        next_cycle();
        for (int f = 0; f < 3; f++) begin
            if (f == 2) in_last = 4'b0001;
            settle();
            n_chk++; if (mux_select[1] !== 2'd0) begin n_fail++; $display("FAIL t1_sel0 flit%0d got=%0d want=0", f, mux_select[1]); end
            n_chk++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_ready0 flit%0d got=%b want=0001", f, in_ready); end
            next_cycle();
        end
        in_valid = 4'b0100;
        in_last  = 4'b0000;
        settle();
        n_chk++; if (mux_select[1] !== 2'd2) begin n_fail++; $display("FAIL t1_sel2 got=%0d want=2", mux_select[1]); end
        n_chk++; if (out_active !== 4'b0010) begin n_fail++; $display("FAIL t1_nobubble got=%b want=0010", out_active); end
        n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL t1_ready2 got=%b want=0100", in_ready); end
        next_cycle();
        next_cycle();
        in_last = 4'b0100;
        settle();
        n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL t1_ready2_last got=%b want=0100", in_ready); end
        next_cycle();
        // pointer now 3: input 3 beats input 0
        in_valid  = 4'b1001;
        in_dst[3] = 4'b0010;
        in_last   = 4'b1001;
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t1_idle got=%b want=0000", out_active); end
        next_cycle();
        settle();
        n_chk++; if (mux_select[1] !== 2'd3) begin n_fail++; $display("FAIL t1_ptr3 got=%0d want=3", mux_select[1]); end
        n_chk++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL t1_ready3 got=%b want=1000", in_ready); end
        next_cycle();
        in_valid = 4'b0001;
        settle();
        n_chk++; if (mux_select[1] !== 2'd0) begin n_fail++; $display("FAIL t1_wrap got=%0d want=0", mux_select[1]); end
        n_chk++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_wrap_ready got=%b want=0001", in_ready); end
        next_cycle();
        clear_inputs();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t1_end got=%b want=0000", out_active); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int exp_o;
        clear_inputs();
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        for (int i = 0; i < 4; i++) in_dst[i] = 4'b1000;
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t2_latency got=%b want=0000", out_active); end
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) in_valid = 4'b1000;
            exp_o = k % 4;
            settle();
            n_chk++; if (mux_select[3] !== 2'(exp_o)) begin n_fail++; $display("FAIL t2_order k%0d got=%0d want=%0d", k, mux_select[3], exp_o); end
            n_chk++; if (in_ready !== 4'(1 << exp_o)) begin n_fail++; $display("FAIL t2_ready k%0d got=%b want=%b", k, in_ready, 4'(1 << exp_o)); end
            next_cycle();
        end
        clear_inputs();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t2_end got=%b want=0000", out_active); end
        next_cycle();
    endtask

    task automatic test_parallel();
        clear_inputs();
        in_valid  = 4'b0110;
        in_dst[1] = 4'b0001;
        in_dst[2] = 4'b1000;
        settle();
        n_chk++; if (grant_bus !== 4'b0000) begin n_fail++; $display("FAIL t3_latency got=%b want=0000", grant_bus); end
        next_cycle();
        settle();
        n_chk++; if (grant_bus !== 4'b0110) begin n_fail++; $display("FAIL t3_grant got=%b want=0110", grant_bus); end
        n_chk++; if (mux_select[0] !== 2'd1) begin n_fail++; $display("FAIL t3_sel0 got=%0d want=1", mux_select[0]); end
        n_chk++; if (mux_select[3] !== 2'd2) begin n_fail++; $display("FAIL t3_sel3 got=%0d want=2", mux_select[3]); end
        n_chk++; if (out_active !== 4'b1001) begin n_fail++; $display("FAIL t3_active got=%b want=1001", out_active); end
        in_last = 4'b0110;
        n_chk++; if (in_ready !== 4'b0110) begin n_fail++; $display("FAIL t3_ready got=%b want=0110", in_ready); end
        next_cycle();
        clear_inputs();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t3_end got=%b want=0000", out_active); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        in_valid  = 4'b1000;
        in_dst[3] = 4'b0100;
        settle();
        next_cycle();
        in_valid  = 4'b1001;
        in_dst[0] = 4'b0100;
        out_ready = 4'b1011;
        for (int s = 0; s < 5; s++) begin
            settle();
            n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL t4_ready s%0d got=%b want=0000", s, in_ready); end
            n_chk++; if (out_active !== 4'b0100) begin n_fail++; $display("FAIL t4_lock s%0d got=%b want=0100", s, out_active); end
            n_chk++; if (mux_select[2] !== 2'd3) begin n_fail++; $display("FAIL t4_sel s%0d got=%0d want=3", s, mux_select[2]); end
            n_chk++; if (grant_bus !== 4'b1000) begin n_fail++; $display("FAIL t4_grant s%0d got=%b want=1000", s, grant_bus); end
            next_cycle();
        end
        out_ready = 4'hF;
        in_last   = 4'b1000;
        settle();
        n_chk++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL t4_release got=%b want=1000", in_ready); end
        next_cycle();
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        settle();
        n_chk++; if (mux_select[2] !== 2'd0) begin n_fail++; $display("FAIL t4_next got=%0d want=0", mux_select[2]); end
        n_chk++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL t4_next_ready got=%b want=0001", in_ready); end
        next_cycle();
        clear_inputs();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t4_end got=%b want=0000", out_active); end
        next_cycle();
    endtask

    task automatic test_timeout();
        clear_inputs();
        in_valid  = 4'b0010;
        in_dst[1] = 4'b0100;
        settle();
        next_cycle();
        settle();
        n_chk++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL t5_accept got=%b want=0010", in_ready); end
        next_cycle();
        in_valid = 4'b0000;
        for (int s = 1; s <= 8; s++) begin
            settle();
            n_chk++; if (timeout_pulse !== ((s == 8) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL t5_pulse s%0d got=%b want=%b", s, timeout_pulse, (s == 8) ? 4'b0100 : 4'b0000); end
            n_chk++; if (out_active !== 4'b0100) begin n_fail++; $display("FAIL t5_held s%0d got=%b want=0100", s, out_active); end
            next_cycle();
        end
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t5_released got=%b want=0000", out_active); end
        n_chk++; if (timeout_pulse !== 4'b0000) begin n_fail++; $display("FAIL t5_pulse_len got=%b want=0000", timeout_pulse); end
        next_cycle();
    endtask

    task automatic test_dst_err_reset();
        clear_inputs();
        in_valid  = 4'b0001;
        in_dst[0] = 4'b0110;
        settle();
        n_chk++; if (dst_err !== 1'b0) begin n_fail++; $display("FAIL t6_err_early got=%b want=0", dst_err); end
        next_cycle();
        settle();
        n_chk++; if (dst_err !== 1'b1) begin n_fail++; $display("FAIL t6_err got=%b want=1", dst_err); end
        n_chk++; if (out_active !== 4'b0010) begin n_fail++; $display("FAIL t6_route got=%b want=0010", out_active); end
        n_chk++; if (grant_bus !== 4'b0001) begin n_fail++; $display("FAIL t6_grant got=%b want=0001", grant_bus); end
        n_chk++; if (mux_select[3] !== 2'd2) begin n_fail++; $display("FAIL t6_hold_sel got=%0d want=2", mux_select[3]); end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_active got=%b want=0000", out_active); end
        n_chk++; if (grant_bus !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_grant got=%b want=0000", grant_bus); end
        n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_ready got=%b want=0000", in_ready); end
        n_chk++; if (mux_select !== 8'h00) begin n_fail++; $display("FAIL t6_rst_mux got=%h want=00", mux_select); end
        n_chk++; if (dst_err !== 1'b0) begin n_fail++; $display("FAIL t6_rst_err got=%b want=0", dst_err); end
        clear_inputs();
        rst_n = 1'b1;
        next_cycle();
        settle();
        n_chk++; if (out_active !== 4'b0000) begin n_fail++; $display("FAIL t6_post_active got=%b want=0000", out_active); end
        n_chk++; if (dst_err !== 1'b0) begin n_fail++; $display("FAIL t6_post_err got=%b want=0", dst_err); end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_packet_lock();
        test_round_robin();
        test_parallel();
        test_backpressure();
        test_timeout();
        test_dst_err_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
